dcache_wb_buffer: RTL and testbench

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

---
 rtl/dcache_wb_buffer_if.sv | 38 +++
 rtl/dcache_wb_buffer.sv | 162 ++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_buffer_if.sv
// Eviction, memory-write and lookup signals of the dcache write-back buffer.
// slave: buffer side; master: dcache controller / memory side.
interface dcache_wb_buffer_if;
   logic         evict_valid;
   logic         evict_ready;
   logic [27:0]  evict_addr;
   logic [127:0] evict_data;
   logic         wr_req;
   logic [31:0]  wr_addr;
   logic         wr_addr_ready;
   logic [31:0]  wr_data;
   logic         wr_data_valid;
   logic         wr_last;
   logic         wr_data_ready;
   logic         wr_resp_valid;
   logic [27:0]  lookup_addr;
   logic         lookup_hit;
   logic [127:0] lookup_data;
   logic         empty;

   modport slave (
      input  evict_valid, evict_addr, evict_data,
      input  wr_addr_ready, wr_data_ready, wr_resp_valid,
      input  lookup_addr,
      output evict_ready, wr_req, wr_addr,
      output wr_data, wr_data_valid, wr_last,
      output lookup_hit, lookup_data, empty
   );

   modport master (
      output evict_valid, evict_addr, evict_data,
      output wr_addr_ready, wr_data_ready, wr_resp_valid,
      output lookup_addr,
      input  evict_ready, wr_req, wr_addr,
      input  wr_data, wr_data_valid, wr_last,
      input  lookup_hit, lookup_data, empty
   );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Dcache write-back buffer: FIFO of dirty lines drained as addr/4-beat/resp.
// Ports: clk, rst (async, active-low), bus (dcache_wb_buffer_if.slave).
// Macro DCACHE_WB_FORWARD_EN: per-entry address match forwarding on lookup;
// undefined: lookup_hit = any entry pending, lookup_data = 0.
module dcache_wb_buffer #(
   parameter int DEPTH = 2,
   parameter int BEATS = 4
) (
   input  logic              clk,
   input  logic              rst,
   dcache_wb_buffer_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BEATS);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   logic [27:0]      addr_q [DEPTH];
   logic [127:0]     data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   state_t           st_q;
   logic [BW-1:0]    beat_q;
   logic             wr_req_q;
   logic             wr_dv_q;
   logic             wr_last_q;
   logic             push;
   logic             pop;
   logic             hit;
   logic [127:0]     ldata;

   assign bus.evict_ready = (cnt_q < CW'(DEPTH));
   assign push = bus.evict_valid && bus.evict_ready;
   assign pop  = (st_q == RESP) && bus.wr_resp_valid;

   // push and pop never target the same slot: pop needs cnt>0,
   // push needs cnt<DEPTH, so wptr==rptr cannot hold for both
   always_comb begin
      vld_d  = vld_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (pop) begin
         vld_d[rptr_q] = 1'b0;
         rptr_d        = rptr_q + 1'b1;
      end
      if (push) begin
         vld_d[wptr_q] = 1'b1;
         wptr_d        = wptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wptr_q] <= bus.evict_addr;
         data_q[wptr_q] <= bus.evict_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // drain FSM; the head stays in the FIFO until its response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q      <= IDLE;
         beat_q    <= '0;
         wr_req_q  <= 1'b0;
         wr_dv_q   <= 1'b0;
         wr_last_q <= 1'b0;
      end else begin
         unique case (st_q)
            IDLE: begin
               if (cnt_q != '0) begin
                  st_q     <= ADDR;
                  wr_req_q <= 1'b1;
               end
            end
            ADDR: begin
               if (bus.wr_addr_ready) begin
                  st_q      <= DATA;
                  wr_req_q  <= 1'b0;
                  wr_dv_q   <= 1'b1;
                  beat_q    <= '0;
                  wr_last_q <= (BEATS == 1);
               end
            end
            DATA: begin
               if (bus.wr_data_ready) begin
                  if (beat_q == BW'(BEATS - 1)) begin
                     st_q      <= RESP;
                     wr_dv_q   <= 1'b0;
                     wr_last_q <= 1'b0;
                     beat_q    <= '0;
                  end else begin
                     beat_q    <= beat_q + 1'b1;
                     wr_last_q <= (beat_q == BW'(BEATS - 2));
                  end
               end
            end
            RESP: begin
               if (bus.wr_resp_valid) st_q <= IDLE;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign bus.wr_req        = wr_req_q;
   assign bus.wr_addr       = wr_req_q ? {addr_q[rptr_q], 4'h0} : '0;
   assign bus.wr_data_valid = wr_dv_q;
   assign bus.wr_last       = wr_last_q;
   assign bus.wr_data       = wr_dv_q ?
                              data_q[rptr_q][{beat_q, 5'b0} +: 32] : '0;
   assign bus.empty         = (vld_q == '0) && (st_q == IDLE);

`ifdef DCACHE_WB_FORWARD_EN
   logic [PW-1:0] idx;

   // walk oldest to youngest so the youngest match overrides
   always_comb begin
      hit   = 1'b0;
      ldata = '0;
      idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rptr_q + PW'(i);
         if (vld_q[idx] && (addr_q[idx] == bus.lookup_addr)) begin
            hit   = 1'b1;
            ldata = data_q[idx];
         end
      end
   end
`else
   logic unused_lookup;

   assign unused_lookup = ^bus.lookup_addr;
   assign hit           = (cnt_q != '0);
   assign ldata         = '0;
`endif

   assign bus.lookup_hit  = hit;
   assign bus.lookup_data = ldata;
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Bench for dcache_wb_buffer: directed scenarios then random traffic,
// all checked against a queue-based model of pending lines.
module tb_dcache_wb_buffer;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;

   dcache_wb_buffer_if bus();

   dcache_wb_buffer #(.DEPTH(DEPTH), .BEATS(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [27:0]  a;
      logic [127:0] d;
   } line_t;

   line_t       q[$];
   int          phase_m = 0;
   int          beat_m = 0;
   int          total = 0;
   int          bad = 0;
   int          ar_mode = 0;
   int          dr_mode = 0;
   int          rs_mode = 0;
   bit          spur = 0;
   bit          tog = 0;
   bit          ev_fired = 0;
   bit          freed = 0;
   logic [31:0] beats_q[$];
   logic [31:0] addrs_q[$];
   int          last_idx = 0;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [128:0] ref_lookup(logic [27:0] la);
      logic [128:0] r;
      r = '0;
`ifdef DCACHE_WB_FORWARD_EN
      foreach (q[i]) if (q[i].a == la) r = {1'b1, q[i].d};
`else
      r = {(q.size() != 0), 128'h0};
`endif
      return r;
   endfunction

   function automatic logic pick(int mode);
      case (mode)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return tog;
         default: return 1'($urandom_range(1));
      endcase
   endfunction

   task automatic step();
      logic [128:0] lk;
      bit af, df, ef, rf;
      #1;
      lk = ref_lookup(bus.lookup_addr);
      chk("lookup_hit", 128'(bus.lookup_hit), 128'(lk[128]));
      chk("lookup_data", bus.lookup_data, lk[127:0]);
      chk("evict_ready", 128'(bus.evict_ready), 128'(q.size() < DEPTH));
      chk("empty", 128'(bus.empty), 128'(q.size() == 0));
      if (phase_m == 1) begin
         chk("dv_in_data", 128'(bus.wr_data_valid), 128'(1));
         chk("wr_data", 128'(bus.wr_data), 128'(q[0].d[beat_m*32 +: 32]));
         chk("wr_last", 128'(bus.wr_last), 128'(beat_m == 3));
      end else begin
         chk("dv_off", 128'(bus.wr_data_valid), 128'(0));
      end
      if (phase_m != 0 || q.size() == 0)
         chk("wr_req_off", 128'(bus.wr_req), 128'(0));
      else if (bus.wr_req === 1'b1)
         chk("wr_addr", 128'(bus.wr_addr), 128'({q[0].a, 4'h0}));
      ef = bus.evict_valid && bus.evict_ready;
      af = bus.wr_req && bus.wr_addr_ready;
      df = bus.wr_data_valid && bus.wr_data_ready && (phase_m == 1);
      rf = bus.wr_resp_valid && (phase_m == 2);
      ev_fired = ef;
      freed    = rf;
      if (af) begin
         addrs_q.push_back(bus.wr_addr);
         phase_m = 1;
         beat_m  = 0;
      end
      if (df) begin
         beats_q.push_back(bus.wr_data);
         if (bus.wr_last) last_idx = beats_q.size();
         if (beat_m == 3) phase_m = 2;
         else beat_m++;
      end
      if (rf) begin
         void'(q.pop_front());
         phase_m = 0;
      end
      if (ef) q.push_back('{a: bus.evict_addr, d: bus.evict_data});
      @(posedge clk);
      #1;
      tog = ~tog;
      bus.wr_addr_ready = pick(ar_mode);
      bus.wr_data_ready = pick(dr_mode);
      if (phase_m == 2) bus.wr_resp_valid = pick(rs_mode);
      else bus.wr_resp_valid = spur && ($urandom_range(3) == 0);
   endtask

   task automatic evict(logic [27:0] a, logic [127:0] d, int lim);
      int n = 0;
      bus.evict_valid = 1'b1;
      bus.evict_addr  = a;
      bus.evict_data  = d;
      do begin
         step();
         n++;
      end while (!ev_fired && n < lim);
      bus.evict_valid = 1'b0;
      chk("evict_accept", 128'(ev_fired), 128'(1));
   endtask

   task automatic drain(int lim);
      int n = 0;
      while ((q.size() != 0 || phase_m != 0) && n < lim) begin
         step();
         n++;
      end
      chk("drain_timeout", 128'(n < lim), 128'(1));
      step();
      chk("drained_empty", 128'(bus.empty), 128'(1));
   endtask

   task automatic clr_rec();
      beats_q.delete();
      addrs_q.delete();
      last_idx = 0;
   endtask

   initial begin
      logic [127:0] d1;
      logic [127:0] d2;
      int n;
      rst = 1'b0;
      bus.evict_valid   = 1'b0;
      bus.evict_addr    = '0;
      bus.evict_data    = '0;
      bus.wr_addr_ready = 1'b0;
      bus.wr_data_ready = 1'b0;
      bus.wr_resp_valid = 1'b0;
      bus.lookup_addr   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_evict_ready", 128'(bus.evict_ready), 128'(1));
      chk("rst_wr_req", 128'(bus.wr_req), 128'(0));
      chk("rst_wr_addr", 128'(bus.wr_addr), 128'(0));
      chk("rst_wr_dv", 128'(bus.wr_data_valid), 128'(0));
      chk("rst_wr_data", 128'(bus.wr_data), 128'(0));
      chk("rst_wr_last", 128'(bus.wr_last), 128'(0));
      chk("rst_hit", 128'(bus.lookup_hit), 128'(0));
      chk("rst_ldata", bus.lookup_data, 128'(0));
      chk("rst_empty", 128'(bus.empty), 128'(1));
      rst = 1'b1;

      // single line, all ready
      clr_rec();
      evict(28'h0000123, 128'h44444444_33333333_22222222_11111111, 5);
      drain(50);
      chk("r030_addr", 128'(addrs_q[0]), 128'(32'h00001230));
      chk("r030_nbeats", 128'(beats_q.size()), 128'(4));
      chk("r030_b0", 128'(beats_q[0]), 128'(32'h11111111));
      chk("r030_b1", 128'(beats_q[1]), 128'(32'h22222222));
      chk("r030_b2", 128'(beats_q[2]), 128'(32'h33333333));
      chk("r030_b3", 128'(beats_q[3]), 128'(32'h44444444));
      chk("r030_last", 128'(last_idx), 128'(4));

      // back-pressure on the address channel fills the buffer
      clr_rec();
      ar_mode = 1;
      bus.wr_addr_ready = 1'b0;
      evict(28'h0000201, {4{32'hA1A1A1A1}}, 5);
      evict(28'h0000202, {4{32'hA2A2A2A2}}, 5);
      bus.evict_valid = 1'b1;
      bus.evict_addr  = 28'h0000203;
      bus.evict_data  = {4{32'hA3A3A3A3}};
      repeat (4) begin
         step();
         chk("r031_blocked", 128'(ev_fired), 128'(0));
         chk("r031_ready0", 128'(bus.evict_ready), 128'(0));
      end
      ar_mode = 0;
      n = 0;
      do begin
         step();
         n++;
      end while (!ev_fired && n < 40);
      bus.evict_valid = 1'b0;
      chk("r031_third_acc", 128'(ev_fired), 128'(1));
      drain(100);
      chk("r031_n", 128'(addrs_q.size()), 128'(3));
      chk("r031_a0", 128'(addrs_q[0]), 128'(32'h00002010));
      chk("r031_a2", 128'(addrs_q[2]), 128'(32'h00002030));

      // toggling data ready
      clr_rec();
      dr_mode = 2;
      evict(28'h0000300, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 5);
      drain(80);
      chk("r032_nbeats", 128'(beats_q.size()), 128'(4));
      chk("r032_b1", 128'(beats_q[1]), 128'(32'hBBBB0001));
      chk("r032_b3", 128'(beats_q[3]), 128'(32'hDDDD0003));
      dr_mode = 0;

      // youngest match wins; same-cycle eviction not yet visible
      ar_mode = 1;
      bus.wr_addr_ready = 1'b0;
      d1 = {4{32'h0BAD0001}};
      d2 = {4{32'h0600D002}};
      bus.lookup_addr = 28'h0000ABC;
      evict(28'h0000ABC, d1, 5);
      evict(28'h0000ABC, d2, 5);
      #1;
`ifdef DCACHE_WB_FORWARD_EN
      chk("r033_hit", 128'(bus.lookup_hit), 128'(1));
      chk("r033_data", bus.lookup_data, d2);
      bus.lookup_addr = 28'h0000ABD;
      #1;
      chk("r033_miss", 128'(bus.lookup_hit), 128'(0));
`else
      chk("r029_hit", 128'(bus.lookup_hit), 128'(1));
      chk("r029_data", bus.lookup_data, 128'(0));
      bus.lookup_addr = 28'h0000ABD;
      #1;
      chk("r029_hit2", 128'(bus.lookup_hit), 128'(1));
`endif
      ar_mode = 0;
      drain(100);
      bus.lookup_addr = 28'h00005A5;
      evict(28'h00005A5, {4{32'h5A5A5A5A}}, 5);
      step();
      drain(60);

      // reset in the middle of a burst
      evict(28'h0000777, {4{32'h77777777}}, 5);
      n = 0;
      while (!(phase_m == 1 && beat_m == 2) && n < 20) begin
         step();
         n++;
      end
      chk("r034_reach", 128'(n < 20), 128'(1));
      rst = 1'b0;
      #1;
      q.delete();
      phase_m = 0;
      beat_m  = 0;
      chk("r034_dv", 128'(bus.wr_data_valid), 128'(0));
      chk("r034_empty", 128'(bus.empty), 128'(1));
      chk("r034_ready", 128'(bus.evict_ready), 128'(1));
      chk("r034_req", 128'(bus.wr_req), 128'(0));
      @(posedge clk);
      #1;
      rst  = 1'b1;
      spur = 1;
      repeat (10) step();
      spur = 0;

      // accept and free on the same edge
      rs_mode = 1;
      evict(28'h0000801, {4{32'h80180180}}, 5);
      n = 0;
      while (phase_m != 2 && n < 30) begin
         step();
         n++;
      end
      chk("r035_reach", 128'(phase_m), 128'(2));
      rs_mode = 0;
      bus.wr_resp_valid = 1'b1;
      bus.evict_valid   = 1'b1;
      bus.evict_addr    = 28'h0000802;
      bus.evict_data    = {4{32'h80280280}};
      step();
      bus.evict_valid = 1'b0;
      chk("r035_both", 128'({ev_fired, freed}), 128'(2'b11));
      #1;
      chk("r035_ready1", 128'(bus.evict_ready), 128'(1));
      evict(28'h0000803, {4{32'h80380380}}, 5);
      #1;
      chk("r035_full", 128'(bus.evict_ready), 128'(0));
      drain(100);

      // random traffic
      ar_mode = 3;
      dr_mode = 3;
      rs_mode = 3;
      spur    = 1;
      for (int i = 0; i < 2000; i++) begin
         bus.evict_valid = ($urandom_range(2) == 0);
         bus.evict_addr  = 28'($urandom_range(7));
         bus.evict_data  = {$urandom, $urandom, $urandom, $urandom};
         bus.lookup_addr = 28'($urandom_range(7));
         step();
      end
      bus.evict_valid = 1'b0;
      spur = 0;
      drain(500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
